// File: rtl/pulse_count_reader.sv
// pulse_count_reader: extends the 6-bit pulse count into a wide total and reports per-gate-window counts.
// Optional PULSE_COUNT_READER_SAT_EN makes the wrap counter saturate and clamps results to all-ones.
module pulse_count_reader #(
    parameter int LOW_W = 6,
    parameter int UPPER_W = 26,
    localparam int W = LOW_W + UPPER_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [LOW_W-1:0] count_in,
    input  logic             gate,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [W-1:0]     rd_data,
    output logic             overrun,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [LOW_W-1:0] s_low;
    logic [UPPER_W-1:0] upper, upper_nx;
    logic [W-1:0] base, ext, result;
    logic gate_q, rise, fall, wrap;
    assign ext = {upper, s_low};
    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;
    // count_in advances by at most one per clock, so a decrease can only be 63->0
    assign wrap = count_in < s_low;
    assign rd_valid = state == DONE;
    assign busy = state == RUN;
`ifdef PULSE_COUNT_READER_SAT_EN
    assign upper_nx = (wrap && !(&upper)) ? upper + UPPER_W'(1) : upper;
    assign result = (&upper) ? '1 : ext - base;
`else
    assign upper_nx = wrap ? upper + UPPER_W'(1) : upper;
    assign result = ext - base;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = rise ? RUN : IDLE;
            RUN:     state_nx = fall ? DONE : RUN;
            DONE:    state_nx = rd_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            s_low <= '0;
            upper <= '0;
            base <= '0;
            gate_q <= 1'b0;
            rd_data <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            s_low <= count_in;
            upper <= upper_nx;
            gate_q <= gate;
            if (state == IDLE && rise)
                base <= ext;
            if (state == RUN && fall)
                rd_data <= result;
            // a handshake on the same edge as a dropped window still clears overrun
            if (state == DONE && rd_ready)
                overrun <= 1'b0;
            else if (state == DONE && rise)
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pulse_count_reader.sv
// tb_pulse_count_reader: table-driven gate windows plus hand-written overrun, reset and saturation sequences.
module tb_pulse_count_reader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [5:0] count_in = '0;
    logic gate = 1'b0, gate2 = 1'b0, rd_ready = 1'b0;
    logic rd_valid, overrun, busy, rd_valid2, overrun2, busy2;
    logic [31:0] rd_data;
    logic [7:0] rd_data2;
    int checks = 0, errors = 0;

    pulse_count_reader dut (
        .clk(clk), .reset_n(reset_n), .count_in(count_in), .gate(gate), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .overrun(overrun), .busy(busy)
    );
    pulse_count_reader #(.LOW_W(6), .UPPER_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .count_in(count_in), .gate(gate2), .rd_ready(1'b0),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .overrun(overrun2), .busy(busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int start;
        int hold;
        int steps;
        logic [31:0] exp;
    } win_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inc();
        count_in = count_in + 6'd1;
        tick();
    endtask

    task automatic goto(input int v);
        while (int'(count_in) != v) inc();
        tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic window(input int hold, input int steps, input logic [31:0] exp);
        gate = 1'b1;
        tick();
        chk("busy_run", 32'(busy), 1);
        repeat (hold) tick();
        repeat (steps) inc();
        tick();
        gate = 1'b0;
        chk("valid_before_fall_edge", 32'(rd_valid), 0);
        tick();
        chk("valid_after_fall", 32'(rd_valid), 1);
        chk("data", rd_data, exp);
        chk("busy_done", 32'(busy), 0);
        chk("overrun_clean", 32'(overrun), 0);
        tick();
        chk("data_stable", rd_data, exp);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("valid_after_hs", 32'(rd_valid), 0);
    endtask

    initial begin
        win_t tbl[6];
        logic [31:0] sat_exp;
        tbl[0] = '{start: 0, hold: 10, steps: 0, exp: 32'd0};
        tbl[1] = '{start: 0, hold: 0, steps: 133, exp: 32'd133};
        tbl[2] = '{start: 63, hold: 20, steps: 1, exp: 32'd1};
        tbl[3] = '{start: 10, hold: 0, steps: 5, exp: 32'd5};
        tbl[4] = '{start: 60, hold: 3, steps: 10, exp: 32'd10};
        tbl[5] = '{start: 5, hold: 0, steps: 64, exp: 32'd64};
        #1;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            goto(tbl[i].start);
            window(tbl[i].hold, tbl[i].steps, tbl[i].exp);
        end
        // result pending while a second window starts
        gate = 1'b1;
        tick();
        repeat (3) inc();
        gate = 1'b0;
        tick();
        chk("ovr_valid", 32'(rd_valid), 1);
        chk("ovr_data", rd_data, 3);
        gate = 1'b1;
        tick();
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_busy", 32'(busy), 0);
        inc();
        gate = 1'b0;
        tick();
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_data_kept", rd_data, 3);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("ovr_clr_valid", 32'(rd_valid), 0);
        chk("ovr_clr", 32'(overrun), 0);
        window(0, 2, 32'd2);
        // rise on the handshake edge: window dropped, overrun ends clear
        gate = 1'b1;
        tick();
        inc();
        gate = 1'b0;
        tick();
        chk("same_valid", 32'(rd_valid), 1);
        rd_ready = 1'b1;
        gate = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("same_overrun", 32'(overrun), 0);
        chk("same_valid_clr", 32'(rd_valid), 0);
        chk("same_idle", 32'(busy), 0);
        gate = 1'b0;
        tick();
        tick();
        chk("same_no_result", 32'(rd_valid), 0);
        // reset in the middle of a window
        gate = 1'b1;
        tick();
        repeat (40) inc();
        chk("mid_busy", 32'(busy), 1);
        reset_n = 1'b0;
        gate = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(rd_valid), 0);
        chk("mid_rst_data", rd_data, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(rd_valid), 0);
        window(0, 5, 32'd5);
        // narrow wrap counter instance, 300 steps in one window
`ifdef PULSE_COUNT_READER_SAT_EN
        sat_exp = 32'd255;
`else
        sat_exp = 32'd44;
`endif
        gate2 = 1'b1;
        tick();
        repeat (300) inc();
        tick();
        gate2 = 1'b0;
        tick();
        chk("narrow_valid", 32'(rd_valid2), 1);
        chk("narrow_data", 32'(rd_data2), sat_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
